// File: rtl/dualram_readback_checker.sv
// dualram_readback_checker
//   Sweeps a pre-filled true-dual-port RAM on both ports in parallel and
//   compares every word against the writer's pattern (word k holds k+1,
//   zero-extended to DATA_W). Port A covers 0..HALF-1 and port B covers
//   HALF..DEPTH-1. The block only drives read enables and addresses; the
//   RAM write enables are tied low at the level above.
//
//   Optional build macro: CHK_FIRST_ERR_EN adds capture of the first
//   mismatch seen after start (first_err_* outputs).
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin a sweep (only honoured in IDLE)
//   ena/addra/douta port A read enable, address, read data
//   enb/addrb/doutb port B read enable, address, read data
//   busy            high in READ, DRAIN and DONE
//   done            one-cycle pulse at the end of a sweep
//   pass            both error counts zero; valid from done until next start
//   err_cnt_a/b     saturating per-port mismatch counts
//   first_err_*     (CHK_FIRST_ERR_EN only) valid, port (0=A,1=B), address, data
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; results of the last sweep held
// READ  | issuing one address per port per cycle, HALF cycles
// DRAIN | waiting RD_LAT cycles for the last read data to be compared
// DONE  | one cycle: done pulse, pass registered
`timescale 1ns/1ps
module dualram_readback_checker #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ena,
    output logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] douta,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt_a,
    output logic [ERR_W-1:0]  err_cnt_b
`ifdef CHK_FIRST_ERR_EN
    ,
    output logic              first_err_vld,
    output logic              first_err_port,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
`endif
);

    localparam int HALF = DEPTH / 2;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rd_cnt;
    logic [1:0]        drain_cnt;
    logic              start_acc, rd_last, drain_last;

    logic              vld_pipe [RD_LAT];
    logic [ADDR_W-1:0] pa_pipe  [RD_LAT];
    logic [ADDR_W-1:0] pb_pipe  [RD_LAT];
    logic              cmp_vld;
    logic [DATA_W-1:0] exp_a, exp_b;
    logic              mis_a, mis_b;
    logic [ERR_W-1:0]  err_a_nxt, err_b_nxt;

    assign start_acc  = (state == S_IDLE) && start;
    assign rd_last    = (state == S_READ) && (rd_cnt == '0);
    assign drain_last = (state == S_DRAIN) && (drain_cnt == '0);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)      state_nxt = S_READ;
            S_READ:  if (rd_last)    state_nxt = S_DRAIN;
            S_DRAIN: if (drain_last) state_nxt = S_DONE;
            S_DONE:                  state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // outputs decoded from state
    always_comb begin
        ena  = (state == S_READ);
        enb  = (state == S_READ);
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // down-counters: words left to issue, then read-latency drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt    <= '0;
            drain_cnt <= '0;
        end else begin
            if (start_acc)
                rd_cnt <= ADDR_W'(HALF - 1);
            else if (state == S_READ && rd_cnt != '0)
                rd_cnt <= rd_cnt - ADDR_W'(1);
            if (rd_last)
                drain_cnt <= 2'(RD_LAT - 1);
            else if (state == S_DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - 2'd1;
        end
    end

    // addresses stop advancing on the last READ cycle so they hold afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addra <= '0;
            addrb <= ADDR_W'(HALF);
        end else if (start_acc) begin
            addra <= '0;
            addrb <= ADDR_W'(HALF);
        end else if (state == S_READ && !rd_last) begin
            addra <= addra + ADDR_W'(1);
            addrb <= addrb + ADDR_W'(1);
        end
    end

    // issued addresses travel alongside the RAM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_pipe[i] <= 1'b0;
                pa_pipe[i]  <= '0;
                pb_pipe[i]  <= '0;
            end
        end else begin
            vld_pipe[0] <= (state == S_READ);
            pa_pipe[0]  <= addra;
            pb_pipe[0]  <= addrb;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                pa_pipe[i]  <= pa_pipe[i-1];
                pb_pipe[i]  <= pb_pipe[i-1];
            end
        end
    end

    // expected = addr+1 computed at DATA_W so the top word wraps in data width
    assign cmp_vld = vld_pipe[RD_LAT-1];
    assign exp_a   = DATA_W'(pa_pipe[RD_LAT-1]) + DATA_W'(1);
    assign exp_b   = DATA_W'(pb_pipe[RD_LAT-1]) + DATA_W'(1);
    assign mis_a   = cmp_vld && (douta != exp_a);
    assign mis_b   = cmp_vld && (doutb != exp_b);

    always_comb begin
        err_a_nxt = err_cnt_a;
        err_b_nxt = err_cnt_b;
        if (start_acc) begin
            err_a_nxt = '0;
            err_b_nxt = '0;
        end else begin
            if (mis_a && err_cnt_a != '1) err_a_nxt = err_cnt_a + ERR_W'(1);
            if (mis_b && err_cnt_b != '1) err_b_nxt = err_cnt_b + ERR_W'(1);
        end
    end

    // pass uses the next counts so the final compare in DRAIN is included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_a <= '0;
            err_cnt_b <= '0;
            pass      <= 1'b0;
        end else begin
            err_cnt_a <= err_a_nxt;
            err_cnt_b <= err_b_nxt;
            if (start_acc)
                pass <= 1'b0;
            else if (drain_last)
                pass <= (err_a_nxt == '0) && (err_b_nxt == '0);
        end
    end

`ifdef CHK_FIRST_ERR_EN
    // port A takes priority when both ports miscompare in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_err_vld  <= 1'b0;
            first_err_port <= 1'b0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (start_acc) begin
            first_err_vld  <= 1'b0;
            first_err_port <= 1'b0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (!first_err_vld && (mis_a || mis_b)) begin
            first_err_vld  <= 1'b1;
            first_err_port <= !mis_a;
            first_err_addr <= mis_a ? pa_pipe[RD_LAT-1] : pb_pipe[RD_LAT-1];
            first_err_data <= mis_a ? douta : doutb;
        end
    end
`endif

endmodule

// File: tb/tb_dualram_readback_checker.sv
`timescale 1ns/1ps
module tb_dualram_readback_checker;

    localparam int HALF = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_v [3];
    logic        ena_v [3], enb_v [3], busy_v [3], done_v [3], pass_v [3];
    logic [9:0]  addra_v [3], addrb_v [3];
    logic [15:0] douta_v [3], doutb_v [3];
    logic [9:0]  erra0, errb0, erra1, errb1;
    logic [7:0]  erra2, errb2;
`ifdef CHK_FIRST_ERR_EN
    logic        fev_v [3], fep_v [3];
    logic [9:0]  fea_v [3];
    logic [15:0] fed_v [3];
`endif

    // RAM model: one shared array, per-instance output registers; output holds when not enabled
    logic [15:0] mem [1024];
    logic [15:0] a1 [3], a2 [3], b1 [3], b2 [3];
    int          mlat [3];

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ena_v[d]) a1[d] <= mem[addra_v[d]];
            if (enb_v[d]) b1[d] <= mem[addrb_v[d]];
            a2[d] <= a1[d];
            b2[d] <= b1[d];
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_rd
        assign douta_v[g] = (mlat[g] == 2) ? a2[g] : a1[g];
        assign doutb_v[g] = (mlat[g] == 2) ? b2[g] : b1[g];
    end

    dualram_readback_checker #(.RD_LAT(1), .ERR_W(10)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .ena(ena_v[0]), .addra(addra_v[0]), .douta(douta_v[0]),
        .enb(enb_v[0]), .addrb(addrb_v[0]), .doutb(doutb_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_cnt_a(erra0), .err_cnt_b(errb0)
`ifdef CHK_FIRST_ERR_EN
        , .first_err_vld(fev_v[0]), .first_err_port(fep_v[0]),
        .first_err_addr(fea_v[0]), .first_err_data(fed_v[0])
`endif
    );

    dualram_readback_checker #(.RD_LAT(2), .ERR_W(10)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .ena(ena_v[1]), .addra(addra_v[1]), .douta(douta_v[1]),
        .enb(enb_v[1]), .addrb(addrb_v[1]), .doutb(doutb_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_cnt_a(erra1), .err_cnt_b(errb1)
`ifdef CHK_FIRST_ERR_EN
        , .first_err_vld(fev_v[1]), .first_err_port(fep_v[1]),
        .first_err_addr(fea_v[1]), .first_err_data(fed_v[1])
`endif
    );

    dualram_readback_checker #(.RD_LAT(1), .ERR_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .ena(ena_v[2]), .addra(addra_v[2]), .douta(douta_v[2]),
        .enb(enb_v[2]), .addrb(addrb_v[2]), .doutb(doutb_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .err_cnt_a(erra2), .err_cnt_b(errb2)
`ifdef CHK_FIRST_ERR_EN
        , .first_err_vld(fev_v[2]), .first_err_port(fep_v[2]),
        .first_err_addr(fea_v[2]), .first_err_data(fed_v[2])
`endif
    );

    // view of the instance under test
    int         sel;
    logic       d_done, d_busy, d_pass, d_ena, d_enb;
    logic [9:0] d_addra, d_addrb;
    int         d_erra, d_errb;

    always_comb begin
        d_done  = done_v[sel];
        d_busy  = busy_v[sel];
        d_pass  = pass_v[sel];
        d_ena   = ena_v[sel];
        d_enb   = enb_v[sel];
        d_addra = addra_v[sel];
        d_addrb = addrb_v[sel];
        case (sel)
            1:       begin d_erra = int'(erra1); d_errb = int'(errb1); end
            2:       begin d_erra = int'(erra2); d_errb = int'(errb2); end
            default: begin d_erra = int'(erra0); d_errb = int'(errb0); end
        endcase
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // mode 0: k+1 pattern, 1: all zero; corrupt selects planted bad words
    task automatic fill(input int mode, input int corrupt);
        for (int k = 0; k < 1024; k++) mem[k] = (mode == 0) ? 16'(k + 1) : 16'h0000;
        case (corrupt)
            1: begin mem[5] = 16'hDEAD; mem[700] = 16'h0000; end
            2: begin mem[0] = 16'h1234; mem[512] = 16'h5678; end
            3: begin mem[511] = 16'h0000; mem[1023] = 16'h0000; end
            default: ;
        endcase
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_v[sel] = 1'b0;
    endtask

    // lat = edges after the start-sampling edge until done seen (0 = never)
    task automatic run_seq(input int repulse_at, output int lat, output int ndone,
                           output int bad, output int n_rd);
        pulse_start();
        lat = 0; ndone = 0; bad = 0; n_rd = 0;
        for (int k = 1; k <= 1500; k++) begin
            if (d_ena) begin
                if (d_addra != 10'(n_rd) || d_addrb != 10'(HALF + n_rd) || !d_enb) bad++;
                n_rd++;
            end
            if (lat == 0 && !d_busy) bad++;
            start_v[sel] = (k == repulse_at);
            @(posedge clk);
            #1;
            if (d_done) begin
                ndone++;
                if (lat == 0) lat = k;
            end
            if (lat != 0 && k >= lat + 3) break;
        end
        start_v[sel] = 1'b0;
    endtask

    task automatic wait_done(output int k_out);
        k_out = 0;
        for (int k = 1; k <= 1500; k++) begin
            @(posedge clk);
            #1;
            if (d_done) begin k_out = k; break; end
        end
    endtask

    typedef struct {
        int dut; int mode; int corrupt; int model_lat;
        int exp_lat; int exp_pass; int exp_ea; int exp_eb;
        int fe_vld; int fe_port; int fe_addr; int fe_data;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int lat, ndone, bad, n_rd, k;

        vecs[0] = '{0, 0, 0, 1, 513, 1,   0,   0, 0, 0,   0, 0};
        vecs[1] = '{0, 0, 1, 1, 513, 0,   1,   1, 1, 0,   5, 16'hDEAD};
        vecs[2] = '{0, 0, 2, 1, 513, 0,   1,   1, 1, 0,   0, 16'h1234};
        vecs[3] = '{0, 0, 3, 1, 513, 0,   1,   1, 1, 0, 511, 0};
        vecs[4] = '{0, 1, 0, 1, 513, 0, 512, 512, 1, 0,   0, 0};
        vecs[5] = '{1, 0, 0, 2, 514, 1,   0,   0, 0, 0,   0, 0};
        // model faster than RD_LAT: every word but the held last one miscompares
        vecs[6] = '{1, 0, 0, 1, 514, 0, 511, 511, 1, 0,   0, 2};
        vecs[7] = '{2, 1, 0, 1, 513, 0, 255, 255, 1, 0,   0, 0};
        vecs[8] = '{2, 0, 0, 1, 513, 1,   0,   0, 0, 0,   0, 0};

        for (int d = 0; d < 3; d++) begin start_v[d] = 1'b0; mlat[d] = 1; end
        sel   = 0;
        rst_n = 1'b0;
        fill(0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset ena",   int'(d_ena), 0);
        check("reset enb",   int'(d_enb), 0);
        check("reset busy",  int'(d_busy), 0);
        check("reset done",  int'(d_done), 0);
        check("reset pass",  int'(d_pass), 0);
        check("reset err_a", d_erra, 0);
        check("reset err_b", d_errb, 0);
        check("reset addra", int'(d_addra), 0);
        check("reset addrb", int'(d_addrb), HALF);
`ifdef CHK_FIRST_ERR_EN
        check("reset first_err_vld", int'(fev_v[0]), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 9; i++) begin
            sel = vecs[i].dut;
            mlat[sel] = vecs[i].model_lat;
            fill(vecs[i].mode, vecs[i].corrupt);
            run_seq(0, lat, ndone, bad, n_rd);
            check($sformatf("v%0d done latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d done pulses", i), ndone, 1);
            check($sformatf("v%0d address/busy errors", i), bad, 0);
            check($sformatf("v%0d read cycles", i), n_rd, HALF);
            check($sformatf("v%0d pass", i), int'(d_pass), vecs[i].exp_pass);
            check($sformatf("v%0d err_a", i), d_erra, vecs[i].exp_ea);
            check($sformatf("v%0d err_b", i), d_errb, vecs[i].exp_eb);
            check($sformatf("v%0d idle after", i), int'(d_busy), 0);
`ifdef CHK_FIRST_ERR_EN
            check($sformatf("v%0d first_err_vld", i), int'(fev_v[sel]), vecs[i].fe_vld);
            if (vecs[i].fe_vld != 0) begin
                check($sformatf("v%0d first_err_port", i), int'(fep_v[sel]), vecs[i].fe_port);
                check($sformatf("v%0d first_err_addr", i), int'(fea_v[sel]), vecs[i].fe_addr);
                check($sformatf("v%0d first_err_data", i), int'(fed_v[sel]), vecs[i].fe_data);
            end
`endif
        end

        // start re-pulsed mid-READ is ignored; next accepted start clears results
        sel = 0;
        mlat[0] = 1;
        fill(0, 1);
        run_seq(101, lat, ndone, bad, n_rd);
        check("repulse latency", lat, 513);
        check("repulse done pulses", ndone, 1);
        check("repulse err_a", d_erra, 1);
        check("repulse err_b", d_errb, 1);
        fill(0, 0);
        pulse_start();
        check("restart clears err_a", d_erra, 0);
        check("restart clears err_b", d_errb, 0);
        check("restart busy", int'(d_busy), 1);
        wait_done(k);
        check("restart latency", k, 513);
        check("restart pass", int'(d_pass), 1);
        repeat (3) @(posedge clk);
        pulse_start();
        check("start clears pass", int'(d_pass), 0);
        wait_done(k);
        check("second pass", int'(d_pass), 1);
        repeat (3) @(posedge clk);

        // asynchronous reset in the middle of READ
        fill(0, 1);
        pulse_start();
        repeat (200) @(posedge clk);
        #1;
        check("pre-reset err_a", d_erra, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset ena", int'(d_ena), 0);
        check("mid reset enb", int'(d_enb), 0);
        check("mid reset busy", int'(d_busy), 0);
        check("mid reset err_a", d_erra, 0);
        check("mid reset err_b", d_errb, 0);
        check("mid reset addra", int'(d_addra), 0);
        repeat (2) @(posedge clk);
        #1;
        check("held reset busy", int'(d_busy), 0);
        check("held reset done", int'(d_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        fill(0, 0);
        run_seq(0, lat, ndone, bad, n_rd);
        check("post-reset latency", lat, 513);
        check("post-reset pass", int'(d_pass), 1);
        check("post-reset err_a", d_erra, 0);
        check("post-reset err_b", d_errb, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
